reg_file: RTL and testbench
===========================

// Module: reg_file
// PURPOSE
//   RV32I integer register file: the consuming end of the writeback interface
//   (regwrite / rd_addr / wb_data).
//   - Stores x1..x31. x0 is hardwired to zero.
//   - Two combinational read ports feed the decode stage.
//   - One synchronous write port takes commits from writeback.
//   - A committed-write counter and a debug read port give the bench
//     architectural visibility.
// PARAMETERS
//   XLEN       32   data width of each register and of all data ports
//   CNT_W      32   width of the committed-write counter
//   RESET_VAL  0    value loaded into x1..x31 on reset (XLEN bits)
// PORTS
//   clk_i        in   1      clock; all state updates on the rising edge
//   rst_i        in   1      synchronous, active-high reset
//   regwrite_i   in   1      write enable from writeback
//   rd_addr_i    in   5      destination register index
//   wb_data_i    in   XLEN   write data
//   rs1_addr_i   in   5      read port 1 index
//   rs2_addr_i   in   5      read port 2 index
//   rs1_data_o   out  XLEN   read port 1 data (combinational)
//   rs2_data_o   out  XLEN   read port 2 data (combinational)
//   dbg_addr_i   in   5      debug read index
//   dbg_data_o   out  XLEN   debug read data (combinational, never bypassed)
//   wr_count_o   out  CNT_W  number of committed writes to x1..x31
// BEHAVIOUR
//   Reset: one rising edge with rst_i=1 does all of the following:
//     - every x1..x31 <= RESET_VAL;
//     - wr_count_o <= 0;
//     - any write presented in that cycle is discarded and not counted.
//   Reads during reset: while rst_i=1, rs1_data_o, rs2_data_o and dbg_data_o
//     all read 0. Reset always takes priority, including mid-stream with
//     regwrite_i=1.
//   Write: on a rising edge with rst_i=0, regwrite_i=1 and rd_addr_i!=0:
//     - x[rd_addr_i] <= wb_data_i;
//     - wr_count_o <= wr_count_o + 1.
//     Result is visible on the read ports from the following cycle (1-cycle
//     write latency).
//   x0 writes: regwrite_i=1 with rd_addr_i=0 is dropped. No state changes and
//     wr_count_o does not increment.
//   Reads: a read of index 0 returns 0 on every port, always. A read of any
//     other index returns the stored value, subject to the bypass rule under
//     CONFIGURATION.
//   Same-index reads: rs1 and rs2 may name the same index; both ports return
//     identical data.
//   Counter: wr_count_o wraps modulo 2^CNT_W (all-ones + 1 -> 0) with no
//     saturation or flag.
//   No back-pressure: a write is accepted every cycle it is presented. The
//     block holds no handshake state.
// CONFIGURATION
//   REGFILE_BYPASS_EN defined:
//     - Applies when regwrite_i=1, rst_i=0, rd_addr_i!=0 and rd_addr_i equals
//       rsN_addr_i. rsN_data_o then returns wb_data_i in the same cycle
//       (write-to-read forwarding).
//     - Applies to rs1 and rs2 independently.
//     - dbg_data_o is never bypassed.
//   REGFILE_BYPASS_EN undefined:
//     - rsN_data_o always returns the stored (pre-edge) value.
//     - The hazard unit must stall one extra cycle for a WB->ID dependency.
// TESTING
//   1 Reset then regwrite=1, rd=5, data=0xDEADBEEF; next cycle rs1=5 ->
//     rs1_data=0xDEADBEEF, wr_count=1.
//   2 regwrite=1, rd=0, data=0x12345678; next cycle rs1=0, rs2=0, dbg=0 ->
//     all read 0, wr_count unchanged.
//   3 x7=0x11 stored; same cycle regwrite=1, rd=7, data=0x22, rs1=rs2=7 ->
//     both 0x22 with REGFILE_BYPASS_EN, both 0x11 without; dbg_data=0x11
//     either way. Next cycle all read 0x22.
//   4 Write x3=0xA5A5A5A5, then assert rst_i for 1 cycle with regwrite=1,
//     rd=3, data=0xFFFF0000 -> after reset x3=RESET_VAL, wr_count=0. Reads
//     during the reset cycle return 0.
//   5 CNT_W=4: 15 writes to x1 -> wr_count=15; 16th write -> wr_count=0;
//     x1 holds the 16th data value.
//   6 Fill x1..x31 with index*0x01010101, sweep rs1, rs2 and dbg over 0..31 ->
//     each returns the expected value, index 0 returns 0; wr_count=31.

Source files
------------

// File: rtl/reg_file.sv
// reg_file: RV32I integer register file, the consuming end of writeback.
//
// Stores x1..x31; x0 is hardwired to zero. Two combinational read ports feed
// decode, one synchronous write port takes commits from writeback. A
// committed-write counter and a never-bypassed debug read port expose
// architectural state.
//
// Ports:
//   clk_i       clock, all state updates on the rising edge
//   rst_i       synchronous active-high reset (regs <= RESET_VAL, count <= 0)
//   regwrite_i  write enable from writeback
//   rd_addr_i   destination register index
//   wb_data_i   write data
//   rs1_addr_i  read port 1 index      rs1_data_o  read port 1 data
//   rs2_addr_i  read port 2 index      rs2_data_o  read port 2 data
//   dbg_addr_i  debug read index       dbg_data_o  debug read data
//   wr_count_o  number of committed writes to x1..x31 (wraps)
//
// Configuration macro:
//   REGFILE_BYPASS_EN  when defined, a write to rsN in the current cycle is
//                      forwarded to rsN_data_o combinationally. dbg_data_o is
//                      never forwarded.
module reg_file #(
    parameter int unsigned     XLEN      = 32,
    parameter int unsigned     CNT_W     = 32,
    parameter logic [XLEN-1:0] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             regwrite_i,
    input  logic [4:0]       rd_addr_i,
    input  logic [XLEN-1:0]  wb_data_i,
    input  logic [4:0]       rs1_addr_i,
    input  logic [4:0]       rs2_addr_i,
    output logic [XLEN-1:0]  rs1_data_o,
    output logic [XLEN-1:0]  rs2_data_o,
    input  logic [4:0]       dbg_addr_i,
    output logic [XLEN-1:0]  dbg_data_o,
    output logic [CNT_W-1:0] wr_count_o
);

    // x0 has no storage; index 0 is decoded to zero on every read port.
    logic [XLEN-1:0]  regs_q [1:31];
    logic [XLEN-1:0]  regs_d [1:31];
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic wr_en;
    assign wr_en = regwrite_i && (rd_addr_i != 5'd0);

    function automatic logic [XLEN-1:0] read_reg(input logic [4:0] addr);
        logic [XLEN-1:0] val;
        val = '0;
        for (int i = 1; i < 32; i++) begin
            if (addr == 5'(i)) begin
                val = regs_q[i];
            end
        end
        return val;
    endfunction

    always_comb begin
        regs_d = regs_q;
        cnt_d  = cnt_q;
        if (rst_i) begin
            // Reset wins over any write presented in the same cycle.
            for (int i = 1; i < 32; i++) begin
                regs_d[i] = RESET_VAL;
            end
            cnt_d = '0;
        end else if (wr_en) begin
            for (int i = 1; i < 32; i++) begin
                if (rd_addr_i == 5'(i)) begin
                    regs_d[i] = wb_data_i;
                end
            end
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        regs_q <= regs_d;
        cnt_q  <= cnt_d;
    end

    always_comb begin
        rs1_data_o = read_reg(rs1_addr_i);
        rs2_data_o = read_reg(rs2_addr_i);
        dbg_data_o = read_reg(dbg_addr_i);
`ifdef REGFILE_BYPASS_EN
        // Forward the in-flight write so decode sees it without a stall.
        if (wr_en && (rd_addr_i == rs1_addr_i)) begin
            rs1_data_o = wb_data_i;
        end
        if (wr_en && (rd_addr_i == rs2_addr_i)) begin
            rs2_data_o = wb_data_i;
        end
`endif
        // Stored contents are meaningless to readers while reset is held.
        if (rst_i) begin
            rs1_data_o = '0;
            rs2_data_o = '0;
            dbg_data_o = '0;
        end
    end

    assign wr_count_o = cnt_q;

endmodule

// File: tb/tb_reg_file.sv
module tb_reg_file;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [4:0]  dbga;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] dbg_data;
    logic [31:0] cnt;
    logic [31:0] c_rs1_data;
    logic [31:0] c_rs2_data;
    logic [31:0] c_dbg_data;
    logic [3:0]  c_cnt;

    // Reference state: architectural registers and the count of committed writes.
    logic [31:0] mdl [32];
    logic [31:0] mcnt;

    int errors = 0;
    int checks = 0;

    reg_file dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .regwrite_i (we),
        .rd_addr_i  (rd),
        .wb_data_i  (wd),
        .rs1_addr_i (ra1),
        .rs2_addr_i (ra2),
        .rs1_data_o (rs1_data),
        .rs2_data_o (rs2_data),
        .dbg_addr_i (dbga),
        .dbg_data_o (dbg_data),
        .wr_count_o (cnt)
    );

    reg_file #(.CNT_W(4)) dut_c (
        .clk_i      (clk),
        .rst_i      (rst),
        .regwrite_i (we),
        .rd_addr_i  (rd),
        .wb_data_i  (wd),
        .rs1_addr_i (ra1),
        .rs2_addr_i (ra2),
        .rs1_data_o (c_rs1_data),
        .rs2_data_o (c_rs2_data),
        .dbg_addr_i (dbga),
        .dbg_data_o (c_dbg_data),
        .wr_count_o (c_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_read(input logic [4:0] a, input bit is_dbg);
        if (rst) return 32'h0;
        if (a == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (!is_dbg && we && rd != 5'd0 && rd == a) return wd;
`endif
        return mdl[a];
    endfunction

    // Check all outputs on the falling edge, then commit the model at the rising edge.
    task automatic cycle();
        @(negedge clk);
        chk("rs1", rs1_data, exp_read(ra1, 1'b0));
        chk("rs2", rs2_data, exp_read(ra2, 1'b0));
        chk("dbg", dbg_data, exp_read(dbga, 1'b1));
        chk("cnt", cnt, mcnt);
        chk("cnt4", {28'h0, c_cnt}, {28'h0, mcnt[3:0]});
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
            mcnt = 0;
        end else if (we && rd != 5'd0) begin
            mdl[rd] = wd;
            mcnt = mcnt + 1;
        end
        #1;
    endtask

    task automatic drive(input logic r, input logic w, input logic [4:0] d, input logic [31:0] v,
                         input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad);
        rst = r; we = w; rd = d; wd = v; ra1 = a1; ra2 = a2; dbga = ad;
        cycle();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        mcnt = 0;
        rst = 1'b1; we = 1'b0; rd = '0; wd = '0; ra1 = '0; ra2 = '0; dbga = '0;

        // 1: reset, write x5, read it back next cycle.
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("rst_cnt", cnt, 32'd0);
        drive(0, 1, 5, 32'hDEADBEEF, 5, 5, 5);
        drive(0, 0, 0, 0, 5, 0, 5);
        chk("t1_rs1", rs1_data, 32'hDEADBEEF);
        chk("t1_cnt", cnt, 32'd1);

        // 2: writes to x0 are dropped and not counted.
        drive(0, 1, 0, 32'h12345678, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("t2_rs1", rs1_data, 32'h0);
        chk("t2_dbg", dbg_data, 32'h0);
        chk("t2_cnt", cnt, 32'd1);

        // 3: same-cycle write to a register being read on both ports.
        drive(0, 1, 7, 32'h11, 0, 0, 0);
        rst = 0; we = 1; rd = 7; wd = 32'h22; ra1 = 7; ra2 = 7; dbga = 7;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("t3_rs1", rs1_data, 32'h22);
        chk("t3_rs2", rs2_data, 32'h22);
`else
        chk("t3_rs1", rs1_data, 32'h11);
        chk("t3_rs2", rs2_data, 32'h11);
`endif
        chk("t3_dbg", dbg_data, 32'h11);
        cycle();
        drive(0, 0, 0, 0, 7, 7, 7);
        chk("t3_next", rs2_data, 32'h22);

        // 4: reset overrides a concurrent write; reads are 0 during reset.
        drive(0, 1, 3, 32'hA5A5A5A5, 0, 0, 0);
        rst = 1; we = 1; rd = 3; wd = 32'hFFFF0000; ra1 = 3; ra2 = 7; dbga = 3;
        #1;
        chk("t4_rs1_rst", rs1_data, 32'h0);
        chk("t4_dbg_rst", dbg_data, 32'h0);
        cycle();
        drive(0, 0, 0, 0, 3, 5, 3);
        chk("t4_x3", rs1_data, 32'h0);
        chk("t4_cnt", cnt, 32'd0);

        // 5: 4-bit counter wraps after 16 writes; x1 keeps the last value.
        for (int i = 1; i <= 15; i++) drive(0, 1, 1, 32'h100 + i, 1, 0, 1);
        chk("t5_cnt15", {28'h0, c_cnt}, 32'd15);
        drive(0, 1, 1, 32'h110, 1, 0, 1);
        drive(0, 0, 0, 0, 1, 1, 1);
        chk("t5_wrap", {28'h0, c_cnt}, 32'd0);
        chk("t5_cnt16", cnt, 32'd16);
        chk("t5_x1", dbg_data, 32'h110);

        // 6: fill all registers and sweep every port.
        drive(1, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i < 32; i++) drive(0, 1, 5'(i), i * 32'h01010101, 0, 0, 0);
        for (int i = 0; i < 32; i++) drive(0, 0, 0, 0, 5'(i), 5'(31 - i), 5'((i + 7) % 32));
        chk("t6_cnt", cnt, 32'd31);
        chk("t6_x31", rs1_data, 32'h1F1F1F1F);

        // Random traffic, with occasional resets and frequent read/write collisions.
        for (int n = 0; n < 400; n++) begin
            logic [4:0] r;
            r = 5'($urandom_range(0, 31));
            drive(($urandom_range(0, 29) == 0), ($urandom_range(0, 3) != 0), r, $urandom(),
                  ($urandom_range(0, 2) == 0) ? r : 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 2) == 0) ? r : 5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
